serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder controller that sequences one instance of the team's FullAdder cell across WIDTH operand bits, LSB first.
- Loads operands through a valid/ready handshake.
- Feeds the carry back into the FullAdder's i_x input one cycle later.
- Assembles the sum in a shift register and presents sum, carry-out and signed overflow through a valid/ready handshake.
- Area-minimal arithmetic unit for the CPU datapath.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 38 +++
 rtl/FullAdder.sv | 13 +
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and bounds for the bit-serial adder controller.
// Optional subtract mode is enabled by defining SERIAL_ADD_CTRL_SUB_EN.
package serial_add_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// i_sub exists only when SERIAL_ADD_CTRL_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    import serial_add_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic             i_sub;
`endif
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;

    modport slave (
`ifdef SERIAL_ADD_CTRL_SUB_EN
        input  i_sub,
`endif
        input  i_valid, i_a, i_b, i_cin, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );

    modport master (
`ifdef SERIAL_ADD_CTRL_SUB_EN
        output i_sub,
`endif
        output i_valid, i_a, i_b, i_cin, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );

endinterface

// File: rtl/FullAdder.sv
// One-bit full adder cell shared across the datapath.
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_x,
    output logic o_c,
    output logic o_s
);

    assign o_s = i_a ^ i_b ^ i_x;
    assign o_c = (i_a & i_b) | (i_x & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one FullAdder, LSB first, valid/ready in and out.
// Define SERIAL_ADD_CTRL_SUB_EN to add the i_sub (A-B) mode.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          i_clk,
    input logic          i_rst,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic             cout_r;
    logic             ovf_r;
    logic             fa_c;
    logic             fa_s;
    logic             last;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

    FullAdder u_fa (
        .i_a (a_sh[0]),
        .i_b (b_sh[0]),
        .i_x (carry_r),
        .o_c (fa_c),
        .o_s (fa_s)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        b_ld = bus.i_b;
        c_ld = bus.i_cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        // A-B as A + ~B + 1
        if (bus.i_sub) begin
            b_ld = ~bus.i_b;
            c_ld = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (bus.i_valid) state_nx = ST_RUN;
            ST_RUN:  if (last)        state_nx = ST_DONE;
            ST_DONE: if (bus.i_ready) state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        a_sh    <= bus.i_a;
                        b_sh    <= b_ld;
                        carry_r <= c_ld;
                        cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry_r <= fa_c;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    // hold at WIDTH-1 so the counter never wraps
                    if (last) begin
                        cout_r <= fa_c;
                        ovf_r  <= carry_r ^ fa_c;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = (state == ST_IDLE);
    assign bus.o_valid = (state == ST_DONE);
    assign bus.o_sum   = sum_sh;
    assign bus.o_cout  = cout_r;
    assign bus.o_ovf   = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Subtract vectors run only when SERIAL_ADD_CTRL_SUB_EN is defined.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] es,
                          input logic ec, input logic eo,
                          input string nm);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        bus.i_valid = 1'b1;
        tests++;
        if (bus.o_ready !== 1'b1) begin
            $display("FAIL %s ready_before got=%b exp=1", nm, bus.o_ready);
            fails++;
        end
        tick();
        bus.i_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (bus.o_valid !== (k == 8)) begin
                $display("FAIL %s latency k=%0d got=%b exp=%b",
                         nm, k, bus.o_valid, (k == 8));
                fails++;
            end
        end
        tests++;
        if (bus.o_sum !== es) begin
            $display("FAIL %s sum got=%h exp=%h", nm, bus.o_sum, es);
            fails++;
        end
        tests++;
        if (bus.o_cout !== ec) begin
            $display("FAIL %s cout got=%b exp=%b", nm, bus.o_cout, ec);
            fails++;
        end
        tests++;
        if (bus.o_ovf !== eo) begin
            $display("FAIL %s ovf got=%b exp=%b", nm, bus.o_ovf, eo);
            fails++;
        end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            $display("FAIL %s release got v=%b r=%b exp v=0 r=1",
                     nm, bus.o_valid, bus.o_ready);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({bus.o_ready, bus.o_valid, bus.o_sum, bus.o_cout, bus.o_ovf}
                !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                $display("FAIL reset c%0d got r=%b v=%b s=%h c=%b o=%b exp r=1 v=0 s=00 c=0 o=0",
                         i, bus.o_ready, bus.o_valid, bus.o_sum,
                         bus.o_cout, bus.o_ovf);
                fails++;
            end
        end
    endtask

    task automatic test_add();
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "add_3c_0f");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    endtask

    task automatic test_overflow();
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_7f_01");
        run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, "ovf_80_80_c1");
    endtask

    task automatic test_backpressure();
        bus.i_a     = 8'h3C;
        bus.i_b     = 8'h0F;
        bus.i_cin   = 1'b0;
        bus.i_valid = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            bus.i_valid = k[0];
            bus.i_a     = 8'hAA;
            bus.i_b     = 8'h55;
            tests++;
            if (bus.o_ready !== 1'b0) begin
                $display("FAIL bp_run_ready k=%0d got=%b exp=0", k, bus.o_ready);
                fails++;
            end
            tick();
        end
        bus.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_sum !== 8'h4B ||
                bus.o_ready !== 1'b0) begin
                $display("FAIL bp_hold k=%0d got v=%b s=%h r=%b exp v=1 s=4b r=0",
                         k, bus.o_valid, bus.o_sum, bus.o_ready);
                fails++;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        tests++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            $display("FAIL bp_release got r=%b v=%b exp r=1 v=0",
                     bus.o_ready, bus.o_valid);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        bus.i_a     = 8'hF0;
        bus.i_b     = 8'h0F;
        bus.i_cin   = 1'b1;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.o_ready, bus.o_valid, bus.o_sum, bus.o_cout, bus.o_ovf}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL rst_mid got r=%b v=%b s=%h c=%b o=%b exp r=1 v=0 s=00 c=0 o=0",
                     bus.o_ready, bus.o_valid, bus.o_sum, bus.o_cout, bus.o_ovf);
            fails++;
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++;
            if (bus.o_valid !== 1'b0) begin
                $display("FAIL rst_mid_no_valid k=%0d got=%b exp=0", k, bus.o_valid);
                fails++;
            end
        end
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_rst_12_34");
    endtask

    task automatic test_back_to_back();
        bus.i_a     = 8'h01;
        bus.i_b     = 8'h02;
        bus.i_cin   = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        repeat (9) tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_sum !== 8'h03) begin
            $display("FAIL b2b_first got v=%b s=%h exp v=1 s=03",
                     bus.o_valid, bus.o_sum);
            fails++;
        end
        tick();
        tests++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            $display("FAIL b2b_idle got r=%b v=%b exp r=1 v=0",
                     bus.o_ready, bus.o_valid);
            fails++;
        end
        bus.i_a = 8'h10;
        bus.i_b = 8'h20;
        tick();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        tests++;
        if (bus.o_ready !== 1'b0) begin
            $display("FAIL b2b_accept got r=%b exp r=0", bus.o_ready);
            fails++;
        end
        repeat (8) tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_sum !== 8'h30) begin
            $display("FAIL b2b_second got v=%b s=%h exp v=1 s=30",
                     bus.o_valid, bus.o_sum);
            fails++;
        end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

`ifdef SERIAL_ADD_CTRL_SUB_EN
    task automatic test_sub();
        bus.i_sub = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        bus.i_sub = 1'b0;
    endtask
`endif

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_cin   = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.i_sub   = 1'b0;
`endif
        test_reset();
        test_add();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_CTRL_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
